l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Round-robin request scheduler that shares the single L2 storage datapath among `PORTS` system-bus requesters. It grants one request at a time and sequences the backend operation. For coherent writes it runs the invalidation broadcast to all other ports and collects their acknowledgements. It signals completion to the winning requester with a one-cycle ready pulse. It sits between the `SystemBus` provider ports and the L2 BRAM control logic.

## Interface
- `PORTS`, 2: number of requesters, ≥1
- `PORT_WIDTH`, `$clog2(PORTS)` (min 1): width of port index
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  PORTS  request pending per port; held until that port's `req_ready`
- `req_we`  in  PORTS  1 = write, 0 = read
- `req_ce`  in  PORTS  coherent write; invalidation required (ignored when `req_we`=0)
- `req_ready`  out  PORTS  one-cycle completion pulse, one-hot
- `op_valid`  out  1  backend operation request
- `op_we`  out  1  backend op is a write
- `op_sel`  out  PORT_WIDTH  granted port index; backend muxes addr/data/mask with it
- `op_ready`  in  1  backend accepts op (handshake when `op_valid`&&`op_ready`)
- `op_done`  in  1  backend finished op (read data valid / write committed)
- `inv_valid`  out  PORTS  invalidation request per port
- `inv_ready`  in  PORTS  invalidation acknowledged per port

## Operation
- States: IDLE, ISSUE, WAIT, BCAST, DONE.
- IDLE: if any `req_valid`, capture winner into `sel`, its `req_we` into `we_q`, and `req_we`&&`req_ce` into `ce_q`; go to ISSUE. Otherwise stay.
- Winner: the first valid port at or after `rr_ptr`, scanning upward modulo PORTS.
- ISSUE: `op_valid`=1, `op_we`=`we_q`. On `op_ready`, go to WAIT.
- WAIT: on `op_done`, go to BCAST if `ce_q` and the broadcast mask is non-empty, else DONE.
- Broadcast mask = all ports except `sel`. `board` is cleared on BCAST entry.
- BCAST: `inv_valid[i]` = mask[i] && !board[i]. Set `board[i]` when `inv_valid[i]`&&`inv_ready[i]`. Go to DONE in the cycle where (`board` | accepted) covers the mask.
- DONE: `req_ready[sel]`=1 for exactly this cycle. `rr_ptr` ← (`sel`+1) mod PORTS; the add wraps; for non-power-of-2 PORTS, compare against PORTS-1. Go to IDLE.
- `op_valid`, `inv_valid` and `req_ready` are decoded from state only, never from inputs.
- `op_sel` = `sel` in all states; 0 after reset.
- Requester dropping `req_valid` mid-transaction is a protocol violation: the sequence completes and `req_ready` still pulses.
- `inv_ready` on a port without `inv_valid` is ignored.
- `op_done` outside WAIT is ignored.
- PORTS=1: a coherent write skips BCAST (empty mask).

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `sel`=0, `board`=0, `we_q`=`ce_q`=0. All outputs 0 in the cycle after reset.
- Reset mid-transaction aborts immediately. No `req_ready` is issued and the requester must re-request.
- Minimum read/non-coherent write latency, with request seen in IDLE at cycle T:
  - ISSUE at T+1 (`op_ready`=1)
  - WAIT at T+2 (`op_done`=1)
  - DONE/`req_ready` at T+3
  - IDLE at T+4
- A requester deasserts `req_valid` in the cycle after `req_ready`. Valid still high in IDLE is a new request.
- Coherent write adds ≥1 BCAST cycle. With all acks immediate, `req_ready` comes at T+4.
- Backpressure: `op_valid` stays high through stalled ISSUE cycles. BCAST waits indefinitely; there is no timeout.
- A port whose ack arrived drops `inv_valid` on the next cycle.

## Structure
- Package `l2_arb_pkg`: `arb_state_t` enum (IDLE=0, ISSUE, WAIT, BCAST, DONE).
- Sub-module `rr_pick`: combinational round-robin picker with inputs `req[PORTS]` and `ptr`, outputs `grant_idx` and `any`. It is reused by other shared-resource arbiters.
- All remaining logic (FSM, `sel`/`rr_ptr`/`board` registers, output decode) lives in `l2_arbiter`.

## Test plan
- Port 1 read alone, `op_ready`/`op_done` tied 1 → `op_valid` at T+1, `op_sel`=1, `op_we`=0; `req_ready`=2'b10 at T+3 only.
- Ports 0 and 1 both request continuously (4 transactions) → grants in order 0,1,0,1 (`rr_ptr` wraps 1→0); each `req_ready` is a single-cycle pulse.
- Port 0 coherent write, `inv_ready[1]` delayed 3 cycles → `inv_valid`=2'b10 held 4 cycles, `inv_valid[0]` never set, `req_ready[0]` the cycle after the ack.
- Port 0 non-coherent write (`req_ce`=0) → no BCAST, `inv_valid` stays 0, same latency as read.
- `op_ready` low 2 cycles in ISSUE, `op_done` arriving early in ISSUE → `op_valid` held 3 cycles, early `op_done` ignored, completion only on a WAIT-state `op_done`.
- Reset asserted in WAIT and in BCAST → next cycle all outputs 0, state IDLE, `rr_ptr`=0, no `req_ready` pulse.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 request arbiter and its round-robin picker.
package l2_arb_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StBcast = 3'd3,
    StDone  = 3'd4
  } arb_state_t;

  // Port index width; a single port still needs one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
  import l2_arb_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned PORT_WIDTH = idx_width(PORTS)
) (
  input  logic [PORTS-1:0]      req_i,
  input  logic [PORT_WIDTH-1:0] ptr_i,
  output logic [PORT_WIDTH-1:0] grant_idx_o,
  output logic                  any_o
);

  int unsigned               idx;
  logic [PORT_WIDTH-1:0]     cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant_idx_o = '0;
    any_o       = |req_i;
    idx         = 0;
    cand        = '0;
    for (int k = int'(PORTS) - 1; k >= 0; k--) begin
      idx = 32'(ptr_i) + unsigned'(k);
      if (idx >= PORTS) idx = idx - PORTS;
      cand = PORT_WIDTH'(idx);
      if (req_i[cand]) grant_idx_o = cand;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin L2 datapath arbiter: grants one requester, sequences the backend op
// and, for coherent writes, broadcasts invalidations to every other port.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned PORT_WIDTH = idx_width(PORTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PORTS-1:0]      req_valid_i,
  input  logic [PORTS-1:0]      req_we_i,
  input  logic [PORTS-1:0]      req_ce_i,
  output logic [PORTS-1:0]      req_ready_o,
  output logic                  op_valid_o,
  output logic                  op_we_o,
  output logic [PORT_WIDTH-1:0] op_sel_o,
  input  logic                  op_ready_i,
  input  logic                  op_done_i,
  output logic [PORTS-1:0]      inv_valid_o,
  input  logic [PORTS-1:0]      inv_ready_i
);

  arb_state_t            state_q, state_d;
  logic [PORT_WIDTH-1:0] sel_q, rr_ptr_q;
  logic [PORTS-1:0]      board_q;
  logic                  we_q, ce_q;
  logic [PORT_WIDTH-1:0] grant_idx;
  logic                  any_req;
  logic [PORTS-1:0]      mask, accepted;

  rr_pick #(
    .PORTS      (PORTS),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_rr_pick (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (grant_idx),
    .any_o       (any_req)
  );

  assign mask     = ~(PORTS'(1) << sel_q);
  assign accepted = inv_valid_o & inv_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: if (op_ready_i) state_d = StWait;
      StWait:  if (op_done_i) state_d = (ce_q && (mask != '0)) ? StBcast : StDone;
      StBcast: if (((board_q | accepted) & mask) == mask) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q    <= '0;
      rr_ptr_q <= '0;
      board_q  <= '0;
      we_q     <= 1'b0;
      ce_q     <= 1'b0;
    end else begin
      if (state_q == StIdle && any_req) begin
        sel_q <= grant_idx;
        we_q  <= req_we_i[grant_idx];
        ce_q  <= req_we_i[grant_idx] & req_ce_i[grant_idx];
      end
      if (state_q == StWait && state_d == StBcast) board_q <= '0;
      else if (state_q == StBcast)                board_q <= board_q | accepted;
      if (state_q == StDone) begin
        rr_ptr_q <= (sel_q == PORT_WIDTH'(PORTS - 1)) ? '0 : sel_q + PORT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    op_valid_o  = (state_q == StIssue);
    op_we_o     = (state_q == StIssue) & we_q;
    op_sel_o    = sel_q;
    inv_valid_o = (state_q == StBcast) ? (mask & ~board_q) : '0;
    req_ready_o = (state_q == StDone) ? (PORTS'(1) << sel_q) : '0;
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model.
module tb_l2_arbiter;

  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [P-1:0] req_valid, req_we, req_ce, req_ready;
  logic         op_valid, op_we, op_ready, op_done;
  logic [0:0]   op_sel;
  logic [P-1:0] inv_valid, inv_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.PORTS(P)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_ce_i    (req_ce),
    .req_ready_o (req_ready),
    .op_valid_o  (op_valid),
    .op_we_o     (op_we),
    .op_sel_o    (op_sel),
    .op_ready_i  (op_ready),
    .op_done_i   (op_done),
    .inv_valid_o (inv_valid),
    .inv_ready_i (inv_ready)
  );

  function automatic int pick(int ptr, logic [P-1:0] pend);
    for (int k = 0; k < P; k++) begin
      int i;
      i = (ptr + k) % P;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_we = '0; req_ce = '0;
    op_ready = 1'b0; op_done = 1'b0; inv_ready = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({op_valid, op_we, op_sel, req_ready, inv_valid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 0", {op_valid, op_we, op_sel, req_ready, inv_valid});
    end
  endtask

  task automatic test_single_read();
    req_valid = 2'b10; req_we = 2'b00; req_ce = 2'b00; op_ready = 1'b1; op_done = 1'b1;
    @(negedge clk);
    tests++;
    if ({op_valid, op_sel, op_we, req_ready} !== 5'b1_1_0_00) begin
      fails++;
      $display("FAIL read_issue: got %b want 11000", {op_valid, op_sel, op_we, req_ready});
    end
    @(negedge clk);
    tests++;
    if ({op_valid, req_ready} !== 3'b0_00) begin
      fails++;
      $display("FAIL read_wait: got %b want 000", {op_valid, req_ready});
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL read_ready: got %b want 10", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b00) begin
      fails++;
      $display("FAIL read_ready_pulse: got %b want 00", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [P-1:0] want;
    bit           seen;
    req_valid = 2'b11; req_we = 2'b00;
    for (int n = 0; n < 4; n++) begin
      want = P'(1) << (n % 2);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (req_ready !== 2'b00) seen = 1'b1;
      end
      tests++;
      if (req_ready !== want) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %b want %b", n, req_ready, want);
      end
      req_valid = req_valid & ~want;
      @(negedge clk);
      tests++;
      if (req_ready !== 2'b00) begin
        fails++;
        $display("FAIL rr_pulse[%0d]: got %b want 00", n, req_ready);
      end
      req_valid = (n == 3) ? 2'b00 : 2'b11;
    end
  endtask

  task automatic test_coherent_delay();
    req_valid = 2'b01; req_we = 2'b01; req_ce = 2'b01; inv_ready = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (inv_valid !== 2'b10 || req_ready !== 2'b00) begin
        fails++;
        $display("FAIL coh_bcast[%0d]: inv_valid=%b req_ready=%b want 10/00", i, inv_valid, req_ready);
      end
      if (i == 3) inv_ready = 2'b10;
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b01 || inv_valid !== 2'b00) begin
      fails++;
      $display("FAIL coh_done: req_ready=%b inv_valid=%b want 01/00", req_ready, inv_valid);
    end
    inv_ready = '0; req_valid = '0; req_we = '0; req_ce = '0;
    @(negedge clk);
  endtask

  task automatic test_noncoherent_write();
    logic [P-1:0] inv_seen;
    inv_seen = '0;
    req_valid = 2'b01; req_we = 2'b01; req_ce = 2'b00;
    @(negedge clk);
    tests++;
    if ({op_valid, op_we, op_sel} !== 3'b110) begin
      fails++;
      $display("FAIL ncw_issue: got %b want 110", {op_valid, op_we, op_sel});
    end
    @(negedge clk);
    inv_seen = inv_seen | inv_valid;
    @(negedge clk);
    inv_seen = inv_seen | inv_valid;
    tests++;
    if (req_ready !== 2'b01 || inv_seen !== 2'b00) begin
      fails++;
      $display("FAIL ncw_done: req_ready=%b inv_seen=%b want 01/00", req_ready, inv_seen);
    end
    req_valid = '0; req_we = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    req_valid = 2'b10; req_we = 2'b00; op_ready = 1'b0; op_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (op_valid !== 1'b1 || req_ready !== 2'b00) begin
        fails++;
        $display("FAIL bp_hold[%0d]: op_valid=%b req_ready=%b want 1/00", i, op_valid, req_ready);
      end
    end
    op_ready = 1'b1; op_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (op_valid !== 1'b0 || req_ready !== 2'b00) begin
        fails++;
        $display("FAIL bp_wait: op_valid=%b req_ready=%b want 0/00", op_valid, req_ready);
      end
    end
    op_done = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 2'b10) begin
      fails++;
      $display("FAIL bp_done: got %b want 10", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic do_read(input int port);
    req_valid = P'(1) << port; req_we = '0; req_ce = '0; op_ready = 1'b1; op_done = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) break;
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_read(0);
    req_valid = 2'b10; req_we = 2'b10; req_ce = 2'b10; inv_ready = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (inv_valid !== 2'b01) begin
      fails++;
      $display("FAIL rstb_bcast: got %b want 01", inv_valid);
    end
    rst = 1'b1; req_valid = '0; req_we = '0; req_ce = '0;
    @(negedge clk);
    tests++;
    if ({op_valid, op_we, op_sel, req_ready, inv_valid} !== '0) begin
      fails++;
      $display("FAIL rstb_outputs: got %b want 0", {op_valid, op_we, op_sel, req_ready, inv_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    tests++;
    if (op_valid !== 1'b1 || op_sel !== 1'b0) begin
      fails++;
      $display("FAIL rstb_ptr: op_valid=%b op_sel=%b want 1/0", op_valid, op_sel);
    end
    req_valid = 2'b01;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) seen = 1'b1;
    end
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL rstb_after: got %b want 01", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    req_valid = 2'b10; op_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    tests++;
    if ({op_valid, op_we, op_sel, req_ready, inv_valid} !== '0) begin
      fails++;
      $display("FAIL rstw_outputs: got %b want 0", {op_valid, op_we, op_sel, req_ready, inv_valid});
    end
    rst = 1'b0; op_done = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req_ready !== 2'b00) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rstw_no_ready: got pulse want none");
    end
  endtask

  task automatic test_random();
    logic [P-1:0] pend, pend_we, pend_ce, drove, drove_we, acked, dropped;
    int           ptr, cur, age, done_cnt;
    bit           active, coh, ov_prev;
    pend = '0; pend_we = '0; pend_ce = '0; drove = '0; drove_we = '0; acked = '0;
    ptr = 0; cur = 0; age = 0; done_cnt = 0; active = 1'b0; coh = 1'b0; ov_prev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      dropped = '0;
      if (op_valid && !ov_prev) begin
        cur = pick(ptr, drove);
        tests++;
        if (active || cur < 0 || op_sel !== cur[0] || op_we !== drove_we[cur]) begin
          fails++;
          $display("FAIL rnd_grant: op_sel=%0d op_we=%b want sel=%0d we=%b", op_sel, op_we, cur,
                   (cur >= 0) ? drove_we[cur] : 1'b0);
        end
        active = 1'b1; age = 0; acked = '0;
        coh = (cur >= 0) && pend_we[cur] && pend_ce[cur];
      end
      ov_prev = op_valid;
      if (inv_valid !== '0) begin
        tests++;
        if (!coh || inv_valid[cur] || (inv_valid & acked) !== '0) begin
          fails++;
          $display("FAIL rnd_inv: got %b coh=%b sel=%0d acked=%b", inv_valid, coh, cur, acked);
        end
      end
      if (req_ready !== '0) begin
        tests++;
        if (!active || req_ready !== (P'(1) << cur)) begin
          fails++;
          $display("FAIL rnd_ready: got %b want %b active=%b", req_ready, P'(1) << cur, active);
        end
        if (active) begin
          pend[cur] = 1'b0; dropped[cur] = 1'b1;
          ptr = (cur + 1) % P; done_cnt++;
        end
        active = 1'b0;
      end
      if (active && ++age > 200) begin
        tests++; fails++;
        $display("FAIL rnd_timeout: port %0d never completed", cur);
        break;
      end
      for (int i = 0; i < P; i++) begin
        if (!pend[i] && !dropped[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1; pend_we[i] = 1'($urandom); pend_ce[i] = 1'($urandom);
        end
      end
      req_valid = pend; req_we = pend_we; req_ce = pend_ce;
      op_ready = 1'($urandom); op_done = 1'($urandom); inv_ready = P'($urandom);
      acked = acked | (inv_valid & inv_ready);
      drove = pend; drove_we = pend_we;
    end
    tests++;
    if (done_cnt < 50) begin
      fails++;
      $display("FAIL rnd_progress: got %0d completions want >= 50", done_cnt);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_coherent_delay();
    test_noncoherent_write();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
